// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
//   Definitions shared by the line buffer controller and its neighbours:
//   the controller FSM state encoding, the minimum legal frame dimension and
//   the DRAIN timeout formula.
// ---------------------------------------------------------------------------
package cnn_pkg;

    // Controller FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } lb_state_e;

    // Smallest legal row width and frame height: a 3x3 window needs three of
    // each.
    localparam int MIN_DIM = 3;

    // Upper bound on DRAIN cycles for a row width W. The line buffer holds at
    // most two full rows once streaming stops, so 3*W+3 leaves generous slack
    // before the controller gives up and flags an error.
    function automatic int drain_timeout(input int width);
        return 3 * width + 3;
    endfunction

endpackage

// File: rtl/line_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// line_buffer_ctrl
//   Sequencing controller for a triple-FIFO 3x3 line buffer. A frame is started
//   with a one-cycle start pulse that latches the row width W and the frame
//   height H. The controller first primes two full rows into the buffer
//   (write only), then streams the remaining rows (write + read/shift each
//   accepted pixel), announcing every complete 3x3 window, and finally drains
//   the buffer before pulsing done.
//
//   Handshake: an upstream pixel transfers on a rising edge where
//   s_valid && s_ready. s_ready does not depend on s_valid. fifo_wen/fifo_ren
//   are combinational from the transfer so the line buffer moves on the same
//   edge that accepts the pixel.
//
// Ports
//   clk               clock, rising edge
//   rst               synchronous active-high reset
//   start             one-cycle frame start, latches cfg_width/cfg_height
//   cfg_width         row width W (3..2^ADDR_BIT)
//   cfg_height        frame height H (>=3)
//   s_valid/s_ready   upstream pixel handshake
//   fifo_wen          line buffer write enable
//   fifo_ren          line buffer read/shift enable
//   fifo_depth        latched W, drives the line buffer depth
//   fifo_empty        per-row empty flags from the line buffer
//   fifo_almost_full  per-row almost-full flags from the line buffer
//   win_valid         one-cycle pulse: full 3x3 window on the taps
//   win_row/win_col   position of the window's bottom-right pixel
//   busy              high whenever the FSM is not idle
//   done              one-cycle end-of-frame (or rejected start) pulse
//   err               sticky error flag
// ---------------------------------------------------------------------------
module line_buffer_ctrl
    import cnn_pkg::*;
#(
    parameter int ADDR_BIT = 3,
    parameter int ROW_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_BIT:0]   cfg_width,
    input  logic [ROW_BITS-1:0] cfg_height,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                fifo_wen,
    output logic                fifo_ren,
    output logic [ADDR_BIT:0]   fifo_depth,
    input  logic [2:0]          fifo_empty,
    input  logic [2:0]          fifo_almost_full,
    output logic                win_valid,
    output logic [ROW_BITS-1:0] win_row,
    output logic [ADDR_BIT:0]   win_col,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int CW = ADDR_BIT + 1;   // width / column counter width
    localparam int PW = ADDR_BIT + 2;   // prime counter: counts up to 2*W
    localparam int DW = ADDR_BIT + 3;   // drain counter: counts up to 3*W+3

    localparam logic [CW-1:0]       MAX_W   = CW'(1 << ADDR_BIT);
    localparam logic [CW-1:0]       MIN_W   = CW'(MIN_DIM);
    localparam logic [ROW_BITS-1:0] MIN_H   = ROW_BITS'(MIN_DIM);
    // Streaming begins on the third row of the frame.
    localparam logic [ROW_BITS-1:0] FIRST_STREAM_ROW = ROW_BITS'(2);

    // ---------------------------------------------------------------------
    // State and registers
    // ---------------------------------------------------------------------
    lb_state_e           state_q,     state_d;
    logic [CW-1:0]       width_q,     width_d;
    logic [ROW_BITS-1:0] height_q,    height_d;
    logic [PW-1:0]       prime_cnt_q, prime_cnt_d;
    logic [CW-1:0]       col_q,       col_d;
    logic [ROW_BITS-1:0] row_q,       row_d;
    logic [DW-1:0]       drain_cnt_q, drain_cnt_d;
    logic                err_q,       err_d;
    logic                cfg_done_q,  cfg_done_d;   // done pulse after a rejected start
    logic                win_valid_q, win_valid_d;
    logic [ROW_BITS-1:0] win_row_q,   win_row_d;
    logic [CW-1:0]       win_col_q,   win_col_d;

    // Combinational handshake / line buffer controls before reset gating.
    logic s_ready_c;
    logic wen_c;
    logic ren_c;

    logic          cfg_ok;
    logic [PW-1:0] prime_last;
    logic [DW-1:0] drain_last;

    // Only the top row's almost-full flag matters: it is the row that fills
    // first while priming. The others are kept for interface symmetry.
    logic unused_af;
    assign unused_af = ^fifo_almost_full[1:0];

    assign cfg_ok = (cfg_width >= MIN_W) && (cfg_width <= MAX_W) &&
                    (cfg_height >= MIN_H);

    // Priming writes exactly two rows: the last prime pixel is index 2*W-1.
    assign prime_last = ({1'b0, width_q} << 1) - PW'(1);
    assign drain_last = DW'(drain_timeout(int'(width_q)) - 1);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            width_q     <= '0;
            height_q    <= '0;
            prime_cnt_q <= '0;
            col_q       <= '0;
            row_q       <= '0;
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
            cfg_done_q  <= 1'b0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            prime_cnt_q <= prime_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            drain_cnt_q <= drain_cnt_d;
            err_q       <= err_d;
            cfg_done_q  <= cfg_done_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        prime_cnt_d = prime_cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        drain_cnt_d = drain_cnt_q;
        err_d       = err_q;
        cfg_done_d  = 1'b0;
        win_valid_d = 1'b0;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        s_ready_c   = 1'b0;
        wen_c       = 1'b0;
        ren_c       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        width_d     = cfg_width;
                        height_d    = cfg_height;
                        err_d       = 1'b0;
                        prime_cnt_d = '0;
                        state_d     = ST_PRIME;
                    end else begin
                        // Rejected start: stay idle but report it.
                        err_d      = 1'b1;
                        cfg_done_d = 1'b1;
                    end
                end
            end

            ST_PRIME: begin
                s_ready_c = 1'b1;
                if (s_valid) begin
                    wen_c = 1'b1;
                    // The write still goes ahead; the overflow is only flagged.
                    if (fifo_almost_full[2]) begin
                        err_d = 1'b1;
                    end
                    if (prime_cnt_q == prime_last) begin
                        col_d   = '0;
                        row_d   = FIRST_STREAM_ROW;
                        state_d = ST_STREAM;
                    end else begin
                        prime_cnt_d = prime_cnt_q + PW'(1);
                    end
                end
            end

            ST_STREAM: begin
                s_ready_c = 1'b1;
                if (s_valid) begin
                    wen_c = 1'b1;
                    ren_c = 1'b1;
                    // Columns 0 and 1 of a row lack a left neighbourhood.
                    if (col_q >= CW'(2)) begin
                        win_valid_d = 1'b1;
                        win_row_d   = row_q;
                        win_col_d   = col_q;
                    end
                    if (col_q == width_q - CW'(1)) begin
                        col_d = '0;
                        if (row_q == height_q - ROW_BITS'(1)) begin
                            drain_cnt_d = '0;
                            state_d     = ST_DRAIN;
                        end else begin
                            row_d = row_q + ROW_BITS'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end

            ST_DRAIN: begin
                if (fifo_empty == 3'b111) begin
                    state_d = ST_DONE;
                end else begin
                    ren_c = 1'b1;
                    if (drain_cnt_q == drain_last) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DW'(1);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs: forced low for the whole time rst is high, including the
    // cycle in which it first rises.
    // ---------------------------------------------------------------------
    assign s_ready    = !rst && s_ready_c;
    assign fifo_wen   = !rst && wen_c;
    assign fifo_ren   = !rst && ren_c;
    assign fifo_depth = rst ? '0 : width_q;
    assign win_valid  = !rst && win_valid_q;
    assign win_row    = rst ? '0 : win_row_q;
    assign win_col    = rst ? '0 : win_col_q;
    assign busy       = !rst && (state_q != ST_IDLE);
    assign done       = !rst && ((state_q == ST_DONE) || cfg_done_q);
    assign err        = !rst && err_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_buffer_ctrl
//   Self-checking bench for line_buffer_ctrl. A behavioural model tracks the
//   frame in terms of pixels accepted, line buffer occupancy and drain cycles;
//   the expected window list is built from the frame dimensions alone.
// ---------------------------------------------------------------------------
module tb_line_buffer_ctrl;

    localparam int ADDR_BIT = 3;
    localparam int ROW_BITS = 16;
    localparam int CW       = ADDR_BIT + 1;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [CW-1:0]       cfg_width;
    logic [ROW_BITS-1:0] cfg_height;
    logic                s_valid;
    logic                s_ready;
    logic                fifo_wen;
    logic                fifo_ren;
    logic [CW-1:0]       fifo_depth;
    logic [2:0]          fifo_empty;
    logic [2:0]          fifo_almost_full;
    logic                win_valid;
    logic [ROW_BITS-1:0] win_row;
    logic [CW-1:0]       win_col;
    logic                busy;
    logic                done;
    logic                err;

    always #5 clk = ~clk;

    line_buffer_ctrl #(.ADDR_BIT(ADDR_BIT), .ROW_BITS(ROW_BITS)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .cfg_width        (cfg_width),
        .cfg_height       (cfg_height),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .fifo_wen         (fifo_wen),
        .fifo_ren         (fifo_ren),
        .fifo_depth       (fifo_depth),
        .fifo_empty       (fifo_empty),
        .fifo_almost_full (fifo_almost_full),
        .win_valid        (win_valid),
        .win_row          (win_row),
        .win_col          (win_col),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    // ------------------------------------------------------------------
    // Scoreboard and reference model state
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];      // expected windows, {row, col} packed

    int  phase;                 // 0 idle, 1 accepting pixels, 2 draining, 3 done
    int  m_w, m_h, m_depth;
    int  n_acc;                 // pixels accepted in this frame
    int  occ;                   // pixels held by the line buffer
    int  dcnt;                  // drain cycles spent
    bit  exp_err;
    bit  pend;                  // a window is due this cycle
    bit  rej_done;              // done pulse due after a rejected start
    int  vmode;                 // 0 valid held, 1 toggling, 2 random
    bit  tog;
    bit  stuck;                 // line buffer never reports empty in drain
    bit  af_prime;              // raise almost_full[2] while priming
    int  win_cnt;
    int  done_cnt;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        phase    = 0;
        m_depth  = 0;
        occ      = 0;
        dcnt     = 0;
        exp_err  = 1'b0;
        pend     = 1'b0;
        rej_done = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle: drive inputs, check outputs, then advance the model to
    // what the coming rising edge does.
    task automatic cycle(input bit start_en, input int sw, input int sh);
        bit   acc;
        bit   e_ren;
        logic [31:0] got_win;
        @(negedge clk);
        start      = start_en;
        cfg_width  = CW'(sw);
        cfg_height = ROW_BITS'(sh);
        tog        = ~tog;
        case (vmode)
            0:       s_valid = 1'b1;
            1:       s_valid = tog;
            default: s_valid = ($urandom_range(0, 3) != 0);
        endcase
        if (stuck && phase == 2) fifo_empty = 3'b000;
        else                     fifo_empty = (occ == 0) ? 3'b111 : 3'b000;
        fifo_almost_full = (af_prime && phase == 1 && n_acc < 2 * m_w) ? 3'b100 : 3'b000;
        #1;

        e_ren = (phase == 1 && s_valid && n_acc >= 2 * m_w) ||
                (phase == 2 && fifo_empty != 3'b111);
        check_val("s_ready", s_ready, phase == 1);
        check_val("fifo_wen", fifo_wen, phase == 1 && s_valid);
        check_val("fifo_ren", fifo_ren, e_ren);
        check_val("busy", busy, phase != 0);
        check_val("done", done, phase == 3 || rej_done);
        check_val("err", err, exp_err);
        check_val("fifo_depth", fifo_depth, m_depth);
        check_val("win_valid", win_valid, pend);
        if (pend) begin
            got_win = (32'(win_row) << 16) | 32'(win_col);
            if (exp_q.size() == 0) check_val("win_pos_extra", got_win, 32'hFFFF_FFFF);
            else                   check_val("win_pos", got_win, exp_q.pop_front());
        end
        if (win_valid === 1'b1) win_cnt++;
        if (done === 1'b1) done_cnt++;

        // advance the model across the rising edge
        acc      = (phase == 1) && s_valid;
        pend     = 1'b0;
        rej_done = 1'b0;
        case (phase)
            0: begin
                if (start_en) begin
                    if (sw >= 3 && sw <= (1 << ADDR_BIT) && sh >= 3) begin
                        phase   = 1;
                        m_w     = sw;
                        m_h     = sh;
                        m_depth = sw;
                        n_acc   = 0;
                        occ     = 0;
                        exp_err = 1'b0;
                        exp_q.delete();
                        for (int r = 2; r < sh; r++)
                            for (int c = 2; c < sw; c++)
                                exp_q.push_back((32'(r) << 16) | 32'(c));
                    end else begin
                        exp_err  = 1'b1;
                        rej_done = 1'b1;
                    end
                end
            end
            1: begin
                if (acc) begin
                    if (n_acc < 2 * m_w) begin
                        occ++;
                        if (af_prime) exp_err = 1'b1;
                    end else if ((n_acc - 2 * m_w) % m_w >= 2) begin
                        pend = 1'b1;
                    end
                    n_acc++;
                    if (n_acc == m_w * m_h) begin
                        phase = 2;
                        dcnt  = 0;
                    end
                end
            end
            2: begin
                if (fifo_empty == 3'b111) begin
                    phase = 3;
                end else begin
                    occ--;
                    dcnt++;
                    if (dcnt == 3 * m_w + 3) begin
                        exp_err = 1'b1;
                        phase   = 3;
                    end
                end
            end
            default: phase = 0;
        endcase
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_s_ready"}, s_ready, 0);
        check_val({tag, "_wen"}, fifo_wen, 0);
        check_val({tag, "_ren"}, fifo_ren, 0);
        check_val({tag, "_depth"}, fifo_depth, 0);
        check_val({tag, "_win_valid"}, win_valid, 0);
        check_val({tag, "_win_row"}, win_row, 0);
        check_val({tag, "_win_col"}, win_col, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_err"}, err, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b1;
        #1;
        check_all_zero("rst_hold");
        @(negedge clk);
        #1;
        check_all_zero("rst_after");
        rst     = 1'b0;
        s_valid = 1'b0;
        model_clear();
    endtask

    // Run one frame from its start pulse back to idle.
    task automatic run_frame(input int w, input int h, input int vm,
                             input bit stk, input bit af, input bit mid_start);
        bit did_mid;
        vmode    = vm;
        stuck    = stk;
        af_prime = af;
        win_cnt  = 0;
        done_cnt = 0;
        did_mid  = 1'b0;
        cycle(1'b1, w, h);
        for (int i = 0; i < 1000 && phase != 0; i++) begin
            if (mid_start && !did_mid && phase == 1 && n_acc == 2 * w + 1) begin
                did_mid = 1'b1;
                cycle(1'b1, 7, 9);
            end else begin
                cycle(1'b0, w, h);
            end
        end
        check_val("frame_timeout", phase, 0);
        check_val("win_count", win_cnt, (h - 2) * (w - 2));
        check_val("win_left", exp_q.size(), 0);
        check_val("done_count", done_cnt, 1);
        check_val("depth_kept", fifo_depth, w);
        stuck    = 1'b0;
        af_prime = 1'b0;
    endtask

    task automatic bad_start(input int w, input int h);
        done_cnt = 0;
        cycle(1'b1, w, h);
        cycle(1'b0, w, h);
        cycle(1'b0, w, h);
        check_val("bad_start_done_count", done_cnt, 1);
        check_val("bad_start_err", err, 1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst              = 1'b1;
        start            = 1'b0;
        cfg_width        = '0;
        cfg_height       = '0;
        s_valid          = 1'b0;
        fifo_empty       = 3'b111;
        fifo_almost_full = 3'b000;
        tog              = 1'b0;
        vmode            = 0;
        stuck            = 1'b0;
        af_prime         = 1'b0;
        n_acc            = 0;
        m_w              = 0;
        m_h              = 0;
        model_clear();

        do_reset();

        // Nominal frame, valid held high, then with valid toggling.
        run_frame(5, 4, 0, 1'b0, 1'b0, 1'b0);
        check_val("nominal_err", err, 0);
        run_frame(5, 4, 1, 1'b0, 1'b0, 1'b0);

        // Rejected starts: width too small, too large, height too small.
        bad_start(2, 5);
        bad_start(9, 4);
        bad_start(4, 2);

        // Start while streaming must be ignored; also clears the old err.
        run_frame(4, 3, 2, 1'b0, 1'b0, 1'b1);
        check_val("mid_start_err", err, 0);

        // Reset in the middle of streaming row 2, column 3.
        done_cnt = 0;
        vmode    = 0;
        cycle(1'b1, 5, 4);
        for (int i = 0; i < 200 && !(phase == 1 && n_acc == 13); i++)
            cycle(1'b0, 5, 4);
        check_val("rst_mid_reached", n_acc, 13);
        do_reset();
        check_val("rst_mid_no_done", done_cnt, 0);
        run_frame(5, 4, 2, 1'b0, 1'b0, 1'b0);

        // Drain that never empties: times out after 3*W+3 cycles.
        run_frame(4, 3, 0, 1'b1, 1'b0, 1'b0);
        check_val("drain_timeout_err", err, 1);
        check_val("drain_timeout_cycles", dcnt, 15);

        // Almost-full while priming flags an error but the frame completes.
        run_frame(6, 3, 0, 1'b0, 1'b1, 1'b0);
        check_val("af_err", err, 1);

        // Random frames.
        for (int f = 0; f < 8; f++)
            run_frame($urandom_range(3, 8), $urandom_range(3, 6), 2, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/line_buffer_ctrl.md
LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

Interface
REQ-001 Parameter ADDR_BIT, default 3: address width of each row FIFO in the attached triple FIFO line buffer.
REQ-002 Parameter ROW_BITS, default 16: width of the frame row counter.
REQ-003 Port clk  input  1  single clock; all logic rising-edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port start  input  1  one-cycle pulse that starts a frame and latches cfg_*.
REQ-006 Port cfg_width  input  ADDR_BIT+1  row width W in pixels, legal 3..2^ADDR_BIT.
REQ-007 Port cfg_height  input  ROW_BITS  frame height H in rows, legal >=3.
REQ-008 Port s_valid  input  1  upstream pixel valid.
REQ-009 Port s_ready  output  1  upstream pixel ready; a pixel is accepted when s_valid&s_ready.
REQ-010 Port fifo_wen  output  1  write enable to the line buffer.
REQ-011 Port fifo_ren  output  1  read/shift enable to the line buffer.
REQ-012 Port fifo_depth  output  ADDR_BIT+1  latched W, driven to the line buffer depth input.
REQ-013 Port fifo_empty  input  3  per-row empty flags from the line buffer.
REQ-014 Port fifo_almost_full  input  3  per-row almost-full flags from the line buffer.
REQ-015 Port win_valid  output  1  one-cycle pulse: a complete 3x3 window is present on the line buffer taps.
REQ-016 Port win_row  output  ROW_BITS  row index of the window's bottom-right pixel.
REQ-017 Port win_col  output  ADDR_BIT+1  column index of the window's bottom-right pixel.
REQ-018 Port busy  output  1  high in every state except IDLE.
REQ-019 Port done  output  1  one-cycle pulse at end of frame.
REQ-020 Port err  output  1  sticky error flag, cleared only by rst or an accepted start.

Function
REQ-021 The FSM SHALL have states IDLE, PRIME, STREAM, DRAIN and DONE.
REQ-022 IDLE: s_ready=0, fifo_wen=0, fifo_ren=0; on start with W>=3 and H>=3 latch W/H, clear err, go to PRIME next cycle.
REQ-023 Start with W<3, W>2^ADDR_BIT or H<3 SHALL leave the FSM in IDLE, set err and pulse done the next cycle.
REQ-024 Start while busy=1 SHALL be ignored, with no effect on counters, cfg or err.
REQ-025 PRIME: s_ready=1; each accepted pixel SHALL assert fifo_wen combinationally in the same cycle with fifo_ren=0; after exactly 2*W accepted pixels go to STREAM.
REQ-026 PRIME: an acceptance while fifo_almost_full[2]=1 SHALL set err; the write still proceeds.
REQ-027 STREAM: s_ready=1; each accepted pixel SHALL assert fifo_wen and fifo_ren together in the same cycle.
REQ-028 STREAM: col counts 0..W-1 and wraps to 0; row starts at 2 and increments on each col wrap.
REQ-029 STREAM: an acceptance at col>=2 SHALL produce win_valid=1 on the next cycle, with win_row/win_col registered from that acceptance.
REQ-030 STREAM: when the pixel at row H-1, col W-1 is accepted, go to DRAIN with s_ready=0 from the next cycle.
REQ-031 Gaps in s_valid SHALL stall all counters with no fifo_wen/fifo_ren activity.
REQ-032 DRAIN: fifo_ren=1 and fifo_wen=0 each cycle until fifo_empty==3'b111, then go to DONE.
REQ-033 DRAIN SHALL be bounded at 3*W+3 cycles; on timeout set err and go to DONE.
REQ-034 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-035 Window count per frame SHALL be exactly (H-2)*(W-2).

Reset
REQ-036 While rst=1, the FSM SHALL go to IDLE and all outputs SHALL be 0: s_ready, fifo_wen, fifo_ren, fifo_depth, win_valid, win_row, win_col, busy, done, err.
REQ-037 Reset mid-frame SHALL abandon the frame with no done pulse; the line buffer shares rst and clears with it.

Structure
REQ-038 Shared package cnn_pkg SHALL hold the FSM state enum, MIN_DIM=3 and the DRAIN timeout formula.
REQ-039 The block SHALL contain no sub-modules; the top level instantiates it beside the triple FIFO line buffer.

Verification
REQ-040 W=5, H=4, s_valid held 1 -> 10 PRIME writes, then 10 STREAM wen+ren cycles; 6 win_valid pulses at (row,col) = (2,2),(2,3),(2,4),(3,2),(3,3),(3,4); DRAIN; one done pulse; err=0.
REQ-041 Same frame with s_valid toggling 1,0 -> identical window sequence, with win_valid only on the cycle after each acceptance.
REQ-042 start with cfg_width=2 -> busy stays 0, err=1, done pulses once one cycle later.
REQ-043 start asserted in STREAM of a W=4, H=3 frame -> ignored; 2 windows produced; cfg unchanged.
REQ-044 rst asserted at STREAM row 2, col 3 -> all outputs 0 on the next cycle, no done pulse; a new start runs a clean frame.
REQ-045 Model holds fifo_empty at 3'b000 during DRAIN, W=4 -> timeout after 15 cycles, err=1, done pulses.
